// File: rtl/alu_enc_pkg.sv
// alu_enc_pkg -- shared definitions for the ALU op encoder.
//   Opcode constants (instr[15:11]), the 3-bit ALU codes (identical to the
//   ALU control decoder's encoding), the decoded-entry struct and the
//   RUN/HALTED state type. The helper functions map a 2-bit selector onto
//   the arithmetic/logic group or the shift/rotate group.
package alu_enc_pkg;

  localparam logic [4:0] OP_RALU = 5'b11011;
  localparam logic [4:0] OP_RSHF = 5'b11010;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_SUBI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_ANDI = 5'b01011;
  localparam logic [4:0] OP_ROLI = 5'b10100;
  localparam logic [4:0] OP_SLLI = 5'b10101;
  localparam logic [4:0] OP_RORI = 5'b10110;
  localparam logic [4:0] OP_SRAI = 5'b10111;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_HALT = 5'b00000;

  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_ROL = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_ROR = 3'b010;
  localparam logic [2:0] ALU_SRA = 3'b011;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       imm_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] rd;
    logic       halt;
    logic       err;
  } entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Selector 00/01/10/11 -> ADD/SUB/OR/AND.
  function automatic logic [2:0] arith_op(input logic [1:0] sel);
    logic [2:0] op;
    case (sel)
      2'b00:   op = ALU_ADD;
      2'b01:   op = ALU_SUB;
      2'b10:   op = ALU_OR;
      2'b11:   op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Selector 00/01/10/11 -> ROL/SLL/ROR/SRA.
  function automatic logic [2:0] shift_op(input logic [1:0] sel);
    logic [2:0] op;
    case (sel)
      2'b00:   op = ALU_ROL;
      2'b01:   op = ALU_SLL;
      2'b10:   op = ALU_ROR;
      2'b11:   op = ALU_SRA;
      default: op = ALU_ROL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_enc_decode.sv
// alu_enc_decode -- purely combinational instruction -> decoded entry.
// Ports:
//   instr  in  16  instruction (opcode [15:11], rd [10:8], func [1:0])
//   entry  out     decoded entry; unknown opcodes give ADD with all
//                  enables low and err set
module alu_enc_decode
  import alu_enc_pkg::*;
(
  input  logic [15:0] instr,
  output entry_t      entry
);

  logic [4:0] opcode;
  logic [1:0] func;
  logic       unused_bits;

  assign opcode      = instr[15:11];
  assign func        = instr[1:0];
  assign unused_bits = ^instr[7:2];

  // Opcode table lookup; immediate groups take their selector from opcode[1:0].
  always_comb begin
    entry           = '0;
    entry.alu_op    = ALU_ADD;
    entry.rd        = instr[10:8];
    case (opcode)
      OP_RALU: begin
        entry.alu_op    = arith_op(func);
        entry.reg_write = 1'b1;
      end
      OP_RSHF: begin
        entry.alu_op    = shift_op(func);
        entry.reg_write = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI: begin
        entry.alu_op    = arith_op(opcode[1:0]);
        entry.imm_sel   = 1'b1;
        entry.reg_write = 1'b1;
      end
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRAI: begin
        entry.alu_op    = shift_op(opcode[1:0]);
        entry.imm_sel   = 1'b1;
        entry.reg_write = 1'b1;
      end
      OP_LD: begin
        entry.imm_sel   = 1'b1;
        entry.reg_write = 1'b1;
        entry.mem_read  = 1'b1;
      end
      OP_ST: begin
        entry.imm_sel   = 1'b1;
        entry.mem_write = 1'b1;
      end
      OP_NOP: begin
        entry.reg_write = 1'b0;
      end
      OP_HALT: begin
        entry.halt      = 1'b1;
      end
      default: begin
        entry.err       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_encoder.sv
// alu_op_encoder -- decode stage: instr -> alu_op + operand/writeback controls,
// buffered in a 2-entry skid FIFO with valid/ready on both sides.
// Optional feature macro: ALU_ENC_ILLCNT_EN (adds ill_cnt, a saturating
// count of accepted illegal instructions, cleared only by reset).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     fetch handshake (in_ready registered)
//   instr                 16-bit instruction
//   flush                 sync: empty buffer, return to RUN, drop offered instr
//   out_valid/out_ready   execute handshake on the head entry
//   alu_op..err           head entry fields (hold when out_valid=0)
//   halted                HALT accepted and not yet flushed
//   ill_cnt               illegal-instruction count (macro only)
module alu_op_encoder
  import alu_enc_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef ALU_ENC_ILLCNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       alu_op,
  output logic             imm_sel,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       rd,
  output logic             halt,
  output logic             err,
`ifdef ALU_ENC_ILLCNT_EN
  output logic [CNT_W-1:0] ill_cnt,
`endif
  output logic             halted
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  entry_t     dec;
  entry_t     head;
  entry_t     tail;
  logic [1:0] count;
  logic [1:0] count_next;
  state_t     state;
  state_t     state_next;
  logic       push;
  logic       pop;

  alu_enc_decode u_decode (
    .instr (instr),
    .entry (dec)
  );

  // flush masks both sides of the handshake so nothing moves that cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Occupancy after this cycle's push/pop/flush.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
  end

  // Next state: HALT acceptance stops intake; only flush resumes it.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:    state_next = (push && dec.halt) ? ST_HALTED : ST_RUN;
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Occupancy plus the registered handshake flags derived from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count     <= count_next;
      out_valid <= (count_next != 2'd0);
      in_ready  <= (count_next < DEPTH_CNT) && (state_next == ST_RUN);
    end
  end

  // Entry storage. in_ready guarantees no push when full, so a pop from a
  // full buffer only promotes tail; a push lands in head when head is free
  // or being consumed this cycle, otherwise in tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      if (pop && (count == 2'd2)) begin
        head <= tail;
      end else if (push && ((count == 2'd0) || pop)) begin
        head <= dec;
      end else if (push) begin
        tail <= dec;
      end
    end
  end

`ifdef ALU_ENC_ILLCNT_EN
  // Saturating count of accepted illegal instructions; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt <= '0;
    end else if (push && dec.err && !(&ill_cnt)) begin
      ill_cnt <= ill_cnt + 1'b1;
    end
  end
`endif

  assign alu_op    = head.alu_op;
  assign imm_sel   = head.imm_sel;
  assign reg_write = head.reg_write;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign rd        = head.rd;
  assign halt      = head.halt;
  assign err       = head.err;
  assign halted    = (state == ST_HALTED);

endmodule
